i2s_tdm_rx: RTL and testbench
=============================

// Module: i2s_tdm_rx
// PURPOSE
//  Parametrised serial-audio receiver (I2S stereo or TDM, 2..16 slots) in the mclk domain.
//  Deserialises i_sdata using one-mclk sclk-rise strobes from the clock generator.
//  Emits one sample per slot on a valid/ready stream tagged with channel index.
//  Adds frame-sync checking, I2S/left-justified modes and overrun detection.
// PARAMETERS
//  DATA_RES   24  bits captured per slot, MSB-first; must be <= SLOT_BITS-1
//  SLOT_BITS  32  sclk periods per slot
//  NUM_CH     2   slots per frame (2 = stereo I2S; 4/8/16 = TDM)
//  CH_W       $clog2(NUM_CH) (derived, localparam)
// PORTS
//  mclk         in   1         system clock; all logic on posedge
//  reset        in   1         synchronous, active-high
//  i_sclk_rise  in   1         1-cycle strobe: sclk rising edge occurs this cycle; sample here
//  i_lrclk      in   1         frame clock / TDM frame sync (level)
//  i_sdata      in   1         serial data
//  i_mode       in   1         0 = I2S (1-bit delay), 1 = left-justified (0 delay)
//  i_clr_err    in   1         1-cycle pulse; clears sticky flags
//  o_data       out  DATA_RES  sample, MSB-first as received
//  o_ch         out  CH_W      slot index of o_data (0 = first slot after frame edge = left)
//  o_valid      out  1         o_data/o_ch valid
//  i_ready      in   1         consumer accepts when o_valid && i_ready
//  o_overrun    out  1         sticky: a completed word was dropped
//  o_sync_err   out  1         sticky: frame edge missing or early
//  o_locked     out  1         high in RUN state
// BEHAVIOUR
//  - All sampling only on cycles with i_sclk_rise=1; other cycles hold state.
//  - Frame edge: sampled lrclk 1 on previous strobe, 0 on this strobe. The edge strobe is pos=0.
//  - pos counts strobes 0..FRAME-1, FRAME = NUM_CH*SLOT_BITS. d = 1 (I2S) or 0 (LJ).
//  - i_mode is latched into d at each frame edge; mid-frame changes are ignored.
//  - Slot s captures bits at pos s*SLOT_BITS+d .. s*SLOT_BITS+d+DATA_RES-1, MSB first.
//  - Bits outside that window are ignored.
//  - FSM SEARCH: pos idle, no capture, o_locked=0.
//    - On frame edge -> RUN with pos=0; capture begins in the same strobe if d=0.
//  - FSM RUN:
//    - Expected edge at pos wraps FRAME-1 -> 0; pos then restarts at 0.
//    - Edge at any other pos: o_sync_err<=1, partial word discarded, pos=0, stay RUN (resync).
//    - Strobe where pos would wrap but no edge: o_sync_err<=1, partial word discarded, -> SEARCH.
//  - Word completes on strobe of its last bit; o_valid rises next mclk cycle.
//  - o_data/o_ch are loaded on that same cycle; latency 1 mclk from last-bit strobe.
//  - Output register, depth 1:
//    - o_valid && i_ready clears o_valid, unless a new word loads that cycle (then stays 1).
//    - Word completing while o_valid && !i_ready: new word dropped, o_overrun<=1.
//    - o_data/o_ch stay stable while o_valid && !i_ready.
//  - Sticky flags: set has priority over i_clr_err in the same cycle.
//  - Reset values: o_data=0, o_ch=0, o_valid=0, o_overrun=0, o_sync_err=0, o_locked=0.
//    FSM=SEARCH, pos=0, shift reg=0, lrclk history=1 (no false edge right after reset).
//  - Reset mid-frame: in-flight word and pending o_valid discarded.
//    Relock requires a fresh frame edge.
// TESTING
//  1. I2S, defaults: L=24'hA5A5A5, R=24'h5A5A5A over 3 frames, i_ready=1.
//     -> sequence (A5A5A5,ch0),(5A5A5A,ch1) x3; o_valid 1 cycle after bit-23 strobe; no flags.
//  2. LJ mode (i_mode=1): same data, MSB at pos 0.
//     -> same outputs; captured one strobe earlier than test 1.
//  3. NUM_CH=8 TDM: slot s carries 24'h000100*s+s.
//     -> o_ch 0..7 in order with matching data; o_locked stays 1.
//  4. Hold i_ready=0 across 2 words.
//     -> first word held stable; second dropped; o_overrun=1.
//     -> i_clr_err clears flag; next word delivered normally.
//  5. Early lrclk fall at pos=40, then no edge at next wrap.
//     -> o_sync_err=1 at pos 40 with resync; at wrap FSM->SEARCH, o_locked=0; relocks on next edge.
//  6. Assert reset at pos 20 of slot 1 with o_valid=1.
//     -> all outputs 0 next cycle; no word emitted until after the next frame edge.

Source files
------------

// File: rtl/i2s_tdm_rx_if.sv
// Sample stream between the serial-audio receiver and its consumer.
// The receiver drives data/channel/valid; the consumer drives ready.
interface i2s_tdm_rx_if #(
    parameter int DATA_RES = 24,
    parameter int CH_W     = 1
);
    logic [DATA_RES-1:0] o_data;
    logic [CH_W-1:0]     o_ch;
    logic                o_valid;
    logic                i_ready;

    modport master (
        output o_data,
        output o_ch,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_ch,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/i2s_tdm_rx.sv
// Serial-audio receiver (I2S stereo or TDM) running in the mclk domain.
// Bits are taken only on sclk-rise strobes. A frame edge is lrclk sampled
// high on one strobe and low on the next; that strobe is position 0.
// Each slot yields one DATA_RES-bit word on a depth-1 valid/ready register.
module i2s_tdm_rx #(
    parameter int DATA_RES  = 24,
    parameter int SLOT_BITS = 32,
    parameter int NUM_CH    = 2
) (
    input  logic         mclk,
    input  logic         reset,
    input  logic         i_sclk_rise,
    input  logic         i_lrclk,
    input  logic         i_sdata,
    input  logic         i_mode,
    input  logic         i_clr_err,
    i2s_tdm_rx_if.master rx,
    output logic         o_overrun,
    output logic         o_sync_err,
    output logic         o_locked
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int BIT_W = $clog2(SLOT_BITS);
    localparam logic [CH_W-1:0]  LAST_SLOT = CH_W'(NUM_CH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W:0]   RES_M1    = (BIT_W + 1)'(DATA_RES - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CH_W-1:0]     slot_r;
    logic [BIT_W-1:0]    bit_r;
    logic                lr_prev_r;
    logic                d_r;
    logic [DATA_RES-1:0] shift_r;
    logic [DATA_RES-1:0] data_r;
    logic [CH_W-1:0]     ch_r;
    logic                valid_r;
    logic                overrun_r;
    logic                sync_err_r;
    logic                locked_r;

    logic                edge_s;
    logic                wrap_s;
    logic                act_s;
    logic                sync_set_s;
    logic [CH_W-1:0]     cur_slot_s;
    logic [BIT_W-1:0]    cur_bit_s;
    logic                d_eff_s;
    logic [BIT_W:0]      win_lo_s;
    logic [BIT_W:0]      bit_ext_s;
    logic                in_win_s;
    logic                first_s;
    logic                last_s;
    logic                hold_s;
    logic [DATA_RES-1:0] word_s;

    // A falling lrclk between consecutive strobes marks a frame edge.
    assign edge_s = lr_prev_r & ~i_lrclk;
    assign wrap_s = (slot_r == LAST_SLOT) && (bit_r == LAST_BIT);
    assign hold_s = valid_r & ~rx.i_ready;

    // State register for the lock FSM.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and position of the current strobe; act_s marks a strobe
    // that belongs to a frame (position cur_slot_s/cur_bit_s).
    always_comb begin
        state_nxt_s = state_r;
        act_s       = 1'b0;
        sync_set_s  = 1'b0;
        cur_slot_s  = '0;
        cur_bit_s   = '0;
        if (i_sclk_rise) begin
            case (state_r)
                ST_SEARCH: begin
                    if (edge_s) begin
                        state_nxt_s = ST_RUN;
                        act_s       = 1'b1;
                    end else begin
                        state_nxt_s = ST_SEARCH;
                    end
                end
                ST_RUN: begin
                    if (edge_s) begin
                        // Edge restarts the frame; anywhere but the wrap it is early.
                        act_s      = 1'b1;
                        sync_set_s = ~wrap_s;
                    end else if (wrap_s) begin
                        // Frame ended without an edge: lock is lost.
                        sync_set_s  = 1'b1;
                        state_nxt_s = ST_SEARCH;
                    end else begin
                        act_s = 1'b1;
                        if (bit_r == LAST_BIT) begin
                            cur_slot_s = slot_r + CH_W'(1);
                            cur_bit_s  = '0;
                        end else begin
                            cur_slot_s = slot_r;
                            cur_bit_s  = bit_r + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_SEARCH;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Capture window decode for the current strobe; a new edge applies its
    // own mode immediately so LJ capture can start on the edge strobe.
    always_comb begin
        d_eff_s   = edge_s ? ~i_mode : d_r;
        win_lo_s  = {{BIT_W{1'b0}}, d_eff_s};
        bit_ext_s = {1'b0, cur_bit_s};
        in_win_s  = act_s && (bit_ext_s >= win_lo_s) && (bit_ext_s <= (win_lo_s + RES_M1));
        first_s   = in_win_s && (bit_ext_s == win_lo_s);
        last_s    = in_win_s && (bit_ext_s == (win_lo_s + RES_M1));
        word_s    = {shift_r[DATA_RES-2:0], i_sdata};
    end

    // Frame position, lrclk history and per-frame delay latch.
    always_ff @(posedge mclk) begin
        if (reset) begin
            slot_r    <= '0;
            bit_r     <= '0;
            lr_prev_r <= 1'b1;
            d_r       <= 1'b1;
        end else if (i_sclk_rise) begin
            lr_prev_r <= i_lrclk;
            slot_r    <= cur_slot_s;
            bit_r     <= cur_bit_s;
            if (edge_s) begin
                d_r <= ~i_mode;
            end
        end
    end

    // Shift register; the first window bit starts a fresh word so any
    // partial word from an interrupted slot never leaks into the next one.
    always_ff @(posedge mclk) begin
        if (reset) begin
            shift_r <= '0;
        end else if (in_win_s) begin
            if (first_s) begin
                shift_r <= {{(DATA_RES-1){1'b0}}, i_sdata};
            end else begin
                shift_r <= word_s;
            end
        end else if (sync_set_s) begin
            shift_r <= '0;
        end
    end

    // Depth-1 output register: load on word completion unless a held word
    // is still waiting for the consumer.
    always_ff @(posedge mclk) begin
        if (reset) begin
            data_r  <= '0;
            ch_r    <= '0;
            valid_r <= 1'b0;
        end else if (last_s && !hold_s) begin
            data_r  <= word_s;
            ch_r    <= cur_slot_s;
            valid_r <= 1'b1;
        end else if (valid_r && rx.i_ready) begin
            valid_r <= 1'b0;
        end
    end

    // Sticky error flags (set wins over clear) and lock indication.
    always_ff @(posedge mclk) begin
        if (reset) begin
            overrun_r  <= 1'b0;
            sync_err_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            if (last_s && hold_s) begin
                overrun_r <= 1'b1;
            end else if (i_clr_err) begin
                overrun_r <= 1'b0;
            end
            if (sync_set_s) begin
                sync_err_r <= 1'b1;
            end else if (i_clr_err) begin
                sync_err_r <= 1'b0;
            end
            locked_r <= (state_nxt_s == ST_RUN);
        end
    end

    assign rx.o_data    = data_r;
    assign rx.o_ch      = ch_r;
    assign rx.o_valid   = valid_r;
    assign o_overrun    = overrun_r;
    assign o_sync_err   = sync_err_r;
    assign o_locked     = locked_r;
endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Bench for i2s_tdm_rx: a stereo instance and an 8-slot TDM instance share
// the serial inputs. Frames are generated from sample tables; the expected
// word stream comes straight from the slot/window rules.
module tb_i2s_tdm_rx;
    logic mclk = 1'b0;
    logic reset, sclk_rise, lrclk, sdata, mode, clr_err, ready;
    logic st_ovr, st_serr, st_lock, td_ovr, td_serr, td_lock;

    int total = 0;
    int bad   = 0;

    logic [23:0] smp [16];
    logic [31:0] exp_st[$];
    logic [31:0] got_st[$];
    logic [31:0] exp_td[$];
    logic [31:0] got_td[$];
    logic        watch = 1'b0;
    int          lock_drops = 0;

    i2s_tdm_rx_if #(.DATA_RES(24), .CH_W(1)) st_if ();
    i2s_tdm_rx_if #(.DATA_RES(24), .CH_W(3)) td_if ();

    assign st_if.i_ready = ready;
    assign td_if.i_ready = ready;

    always #5 mclk = ~mclk;

    i2s_tdm_rx #(.DATA_RES(24), .SLOT_BITS(32), .NUM_CH(2)) dut_st (
        .mclk(mclk), .reset(reset), .i_sclk_rise(sclk_rise), .i_lrclk(lrclk),
        .i_sdata(sdata), .i_mode(mode), .i_clr_err(clr_err), .rx(st_if),
        .o_overrun(st_ovr), .o_sync_err(st_serr), .o_locked(st_lock)
    );

    i2s_tdm_rx #(.DATA_RES(24), .SLOT_BITS(32), .NUM_CH(8)) dut_td (
        .mclk(mclk), .reset(reset), .i_sclk_rise(sclk_rise), .i_lrclk(lrclk),
        .i_sdata(sdata), .i_mode(mode), .i_clr_err(clr_err), .rx(td_if),
        .o_overrun(td_ovr), .o_sync_err(td_serr), .o_locked(td_lock)
    );

    // Record every accepted word (the handshake completes on the next posedge).
    always @(negedge mclk) begin
        if (!reset && ready && st_if.o_valid) got_st.push_back({7'd0, st_if.o_ch, st_if.o_data});
        if (!reset && ready && td_if.o_valid) got_td.push_back({5'd0, td_if.o_ch, td_if.o_data});
        if (watch && !td_lock) lock_drops++;
    end

    task automatic strobe(input bit lr, input bit sd);
        repeat (2) @(posedge mclk);
        #1;
        sclk_rise = 1'b1;
        lrclk     = lr;
        sdata     = sd;
        @(posedge mclk);
        #1;
        sclk_rise = 1'b0;
    endtask

    // Drive one frame position; bit comes from slot table if inside the window.
    task automatic drive_pos(input int nch, input int pos, input int d, input bit lr,
                             input bit do_exp, input bit chk_lat);
        int slot, off;
        bit sd, v_before, v_after;
        slot = pos / 32;
        off  = (pos % 32) - d;
        if (off >= 0 && off < 24) sd = smp[slot][23-off];
        else sd = 1'($urandom_range(0, 1));
        v_before = (nch == 2) ? st_if.o_valid : td_if.o_valid;
        strobe(lr, sd);
        if (off == 23) begin
            if (do_exp) begin
                if (nch == 2) exp_st.push_back({8'(slot), smp[slot]});
                else exp_td.push_back({8'(slot), smp[slot]});
            end
            if (chk_lat) begin
                v_after = (nch == 2) ? st_if.o_valid : td_if.o_valid;
                total++;
                if (v_before !== 1'b0 || v_after !== 1'b1) begin
                    bad++;
                    $display("FAIL latency ch%0d pos%0d: valid before/after %b/%b, need 0/1",
                             slot, pos, v_before, v_after);
                end
            end
        end
    endtask

    task automatic send_frames(input int nch, input int nfr, input bit lj,
                               input bit do_exp, input bit chk_lat);
        mode = lj;
        for (int f = 0; f < nfr; f++)
            for (int p = 0; p < nch * 32; p++)
                drive_pos(nch, p, lj ? 0 : 1, (p >= nch * 16), do_exp, chk_lat);
    endtask

    task automatic do_reset();
        reset = 1'b1; sclk_rise = 1'b0; clr_err = 1'b0; lrclk = 1'b1; sdata = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        reset = 1'b0;
        exp_st.delete();
        exp_td.delete();
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
    endtask

    task automatic pulse_clr();
        @(posedge mclk); #1; clr_err = 1'b1;
        @(posedge mclk); #1; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        ready = 1'b1; mode = 1'b0;
        do_reset();
        total++;
        if ({st_if.o_data, st_if.o_ch, st_if.o_valid, st_ovr, st_serr, st_lock} !== 30'd0) begin
            bad++; $display("FAIL reset_st: got %h need 0", {st_if.o_data, st_if.o_ch, st_if.o_valid, st_ovr, st_serr, st_lock});
        end
        total++;
        if ({td_if.o_data, td_if.o_ch, td_if.o_valid, td_ovr, td_serr, td_lock} !== 32'd0) begin
            bad++; $display("FAIL reset_td: got %h need 0", {td_if.o_data, td_if.o_ch, td_if.o_valid, td_ovr, td_serr, td_lock});
        end
    endtask

    task automatic test_stereo(input bit lj, input bit rnd);
        int gb;
        ready = 1'b1;
        do_reset();
        smp[0] = rnd ? 24'($urandom) : 24'hA5A5A5;
        smp[1] = rnd ? 24'($urandom) : 24'h5A5A5A;
        gb = got_st.size();
        send_frames(2, 3, lj, 1'b1, 1'b1);
        repeat (3) @(posedge mclk);
        #1;
        total++;
        if (got_st.size() - gb !== exp_st.size()) begin
            bad++; $display("FAIL stereo_count lj=%0d: got %0d words need %0d", lj, got_st.size() - gb, exp_st.size());
        end
        for (int i = 0; i < exp_st.size(); i++) begin
            if (gb + i < got_st.size()) begin
                total++;
                if (got_st[gb+i] !== exp_st[i]) begin
                    bad++; $display("FAIL stereo_word%0d lj=%0d: got %h need %h", i, lj, got_st[gb+i], exp_st[i]);
                end
            end
        end
        total++;
        if ({st_ovr, st_serr, st_lock} !== 3'b001) begin
            bad++; $display("FAIL stereo_flags lj=%0d: got %b need 001", lj, {st_ovr, st_serr, st_lock});
        end
    endtask

    task automatic test_tdm(input bit rnd);
        int gb, ld;
        ready = 1'b1;
        do_reset();
        for (int s = 0; s < 8; s++) smp[s] = rnd ? 24'($urandom) : 24'(s * 256 + s);
        gb = got_td.size();
        ld = lock_drops;
        mode = 1'b0;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 256; p++) begin
                drive_pos(8, p, 1, (p >= 128), 1'b1, 1'b1);
                if (f == 0 && p == 0) watch = 1'b1;
            end
        repeat (3) @(posedge mclk);
        #1;
        watch = 1'b0;
        total++;
        if (got_td.size() - gb !== exp_td.size()) begin
            bad++; $display("FAIL tdm_count: got %0d words need %0d", got_td.size() - gb, exp_td.size());
        end
        for (int i = 0; i < exp_td.size(); i++) begin
            if (gb + i < got_td.size()) begin
                total++;
                if (got_td[gb+i] !== exp_td[i]) begin
                    bad++; $display("FAIL tdm_word%0d: got %h need %h", i, got_td[gb+i], exp_td[i]);
                end
            end
        end
        total++;
        if (lock_drops - ld !== 0 || td_lock !== 1'b1 || td_serr !== 1'b0) begin
            bad++; $display("FAIL tdm_lock: drops %0d lock %b serr %b, need 0 1 0", lock_drops - ld, td_lock, td_serr);
        end
    endtask

    task automatic test_overrun();
        int gb;
        ready = 1'b0;
        do_reset();
        smp[0] = 24'($urandom); smp[1] = 24'($urandom);
        gb = got_st.size();
        send_frames(2, 1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({st_if.o_valid, st_if.o_ch, st_if.o_data, st_ovr} !== {1'b1, 1'b0, smp[0], 1'b1}) begin
            bad++; $display("FAIL overrun_hold: got v=%b ch=%0d d=%h ovr=%b need 1 0 %h 1",
                            st_if.o_valid, st_if.o_ch, st_if.o_data, st_ovr, smp[0]);
        end
        exp_st.push_back({8'd0, smp[0]});
        ready = 1'b1;
        pulse_clr();
        total++;
        if (st_ovr !== 1'b0) begin
            bad++; $display("FAIL overrun_clear: got %b need 0", st_ovr);
        end
        send_frames(2, 1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge mclk);
        #1;
        total++;
        if (got_st.size() - gb !== exp_st.size() || st_ovr !== 1'b0) begin
            bad++; $display("FAIL overrun_count: got %0d words ovr %b need %0d 0", got_st.size() - gb, st_ovr, exp_st.size());
        end
        for (int i = 0; i < exp_st.size(); i++) begin
            if (gb + i < got_st.size()) begin
                total++;
                if (got_st[gb+i] !== exp_st[i]) begin
                    bad++; $display("FAIL overrun_word%0d: got %h need %h", i, got_st[gb+i], exp_st[i]);
                end
            end
        end
    endtask

    task automatic test_sync();
        int gb;
        ready = 1'b1;
        do_reset();
        smp[0] = 24'($urandom); smp[1] = 24'($urandom);
        gb = got_st.size();
        send_frames(2, 1, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 40; p++) drive_pos(2, p, 1, (p >= 32), 1'b1, 1'b0);
        drive_pos(2, 0, 1, 1'b0, 1'b1, 1'b0);
        total++;
        if ({st_serr, st_lock} !== 2'b11) begin
            bad++; $display("FAIL sync_early: serr/lock %b need 11", {st_serr, st_lock});
        end
        pulse_clr();
        total++;
        if (st_serr !== 1'b0) begin
            bad++; $display("FAIL sync_clear: got %b need 0", st_serr);
        end
        for (int p = 1; p < 64; p++) drive_pos(2, p, 1, (p >= 32), 1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        total++;
        if ({st_serr, st_lock} !== 2'b10) begin
            bad++; $display("FAIL sync_missing: serr/lock %b need 10", {st_serr, st_lock});
        end
        send_frames(2, 1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge mclk);
        #1;
        total++;
        if (st_lock !== 1'b1 || got_st.size() - gb !== exp_st.size()) begin
            bad++; $display("FAIL sync_relock: lock %b words %0d need 1 %0d", st_lock, got_st.size() - gb, exp_st.size());
        end
        for (int i = 0; i < exp_st.size(); i++) begin
            if (gb + i < got_st.size()) begin
                total++;
                if (got_st[gb+i] !== exp_st[i]) begin
                    bad++; $display("FAIL sync_word%0d: got %h need %h", i, got_st[gb+i], exp_st[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int gb;
        ready = 1'b0;
        do_reset();
        smp[0] = 24'($urandom); smp[1] = 24'($urandom);
        mode = 1'b0;
        for (int p = 0; p <= 52; p++) drive_pos(2, p, 1, (p >= 32), 1'b0, 1'b0);
        total++;
        if (st_if.o_valid !== 1'b1) begin
            bad++; $display("FAIL midreset_pre: valid %b need 1", st_if.o_valid);
        end
        @(posedge mclk); #1; reset = 1'b1;
        @(posedge mclk); #1;
        total++;
        if ({st_if.o_data, st_if.o_ch, st_if.o_valid, st_ovr, st_serr, st_lock} !== 30'd0) begin
            bad++; $display("FAIL midreset_out: got %h need 0", {st_if.o_data, st_if.o_ch, st_if.o_valid, st_ovr, st_serr, st_lock});
        end
        reset = 1'b0;
        ready = 1'b1;
        gb = got_st.size();
        for (int p = 53; p < 64; p++) drive_pos(2, p, 1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge mclk);
        #1;
        total++;
        if (got_st.size() - gb !== 0 || st_lock !== 1'b0) begin
            bad++; $display("FAIL midreset_quiet: words %0d lock %b need 0 0", got_st.size() - gb, st_lock);
        end
        send_frames(2, 1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge mclk);
        #1;
        total++;
        if (got_st.size() - gb !== exp_st.size()) begin
            bad++; $display("FAIL midreset_count: got %0d need %0d", got_st.size() - gb, exp_st.size());
        end
        for (int i = 0; i < exp_st.size(); i++) begin
            if (gb + i < got_st.size()) begin
                total++;
                if (got_st[gb+i] !== exp_st[i]) begin
                    bad++; $display("FAIL midreset_word%0d: got %h need %h", i, got_st[gb+i], exp_st[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; sclk_rise = 1'b0; lrclk = 1'b1; sdata = 1'b0;
        mode = 1'b0; clr_err = 1'b0; ready = 1'b1;
        test_reset();
        test_stereo(1'b0, 1'b0);
        test_stereo(1'b1, 1'b0);
        test_tdm(1'b0);
        test_overrun();
        test_sync();
        test_reset_mid();
        test_stereo(1'($urandom_range(0, 1)), 1'b1);
        test_tdm(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
